// File: rtl/parallel_out_ctrl.sv
// Memory-mapped parallel output port for the single-cycle MIPS core:
// CPU stores are queued in a FIFO and presented through a 4-phase valid/ack handshake.
module parallel_out_ctrl #(
  parameter logic [7:0]  DATA_ADDR = 8'hFF,
  parameter logic [7:0]  STAT_ADDR = 8'hFE,
  parameter int unsigned DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Address,
  input  logic [7:0] RegData,
  input  logic       we,
  output logic       wren,
  output logic       io_sel,
  output logic [7:0] StatusOut,
  output logic [7:0] DataOut,
  output logic       out_valid,
  input  logic       out_ack
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [3:0]      r_count;
  logic            r_overflow;
  logic [7:0]      r_data;
  logic            r_valid;

  logic w_data_hit;
  logic w_stat_hit;
  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_clear;

  assign w_data_hit = (Address == DATA_ADDR);
  assign w_stat_hit = (Address == STAT_ADDR);
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == 4'd0);
  assign w_push_req = we & w_data_hit;
  assign w_pop      = (r_state == IDLE) & ~w_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_clear    = we & w_stat_hit;

  assign io_sel    = w_data_hit | w_stat_hit;
  assign wren      = we & ~io_sel;
  assign StatusOut = w_stat_hit ? {r_overflow, (r_state != IDLE), w_full, w_empty, r_count}
                                : 8'h00;
  assign DataOut   = r_data;
  assign out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= RegData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_clear) begin
        r_overflow <= 1'b0;
      end else if (w_push_req && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == PRESENT);
      if (w_pop) r_data <= r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next = PRESENT;
      PRESENT: if (out_ack)  w_next = RELEASE;
      RELEASE: if (!out_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parallel_out_ctrl.sv
// Directed self-checking bench for parallel_out_ctrl: decode, FIFO, handshake and reset.
module tb_parallel_out_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Address;
  logic [7:0] RegData;
  logic       we;
  logic       wren;
  logic       io_sel;
  logic [7:0] StatusOut;
  logic [7:0] DataOut;
  logic       out_valid;
  logic       out_ack;

  int total = 0;
  int bad   = 0;

  parallel_out_ctrl #(
    .DATA_ADDR(8'hFF),
    .STAT_ADDR(8'hFE),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Address(Address),
    .RegData(RegData),
    .we(we),
    .wren(wren),
    .io_sel(io_sel),
    .StatusOut(StatusOut),
    .DataOut(DataOut),
    .out_valid(out_valid),
    .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    we = 1'b1; Address = 8'hFF; RegData = b;
    step();
    we = 1'b0; Address = 8'hFE;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; out_ack = 1'b0; Address = 8'hFE; RegData = 8'h00;
    step(); step();
    rst = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (DataOut !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", DataOut); end
    total++; if (StatusOut !== 8'h10) begin bad++; $display("FAIL reset_status got=%h exp=10", StatusOut); end
  endtask

  task automatic test_single();
    push(8'hA5); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_nobypass got=%b exp=0", out_valid); end
    total++; if (StatusOut !== 8'h01) begin bad++; $display("FAIL single_queued got=%h exp=01", StatusOut); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (DataOut !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", DataOut); end
    total++; if (StatusOut !== 8'h50) begin bad++; $display("FAIL single_busy got=%h exp=50", StatusOut); end
    out_ack = out_valid; step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b exp=0", out_valid); end
    out_ack = out_valid; step();
    total++; if (StatusOut !== 8'h10) begin bad++; $display("FAIL single_idle got=%h exp=10", StatusOut); end
  endtask

  task automatic test_overflow();
    out_ack = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); #1;
    total++; if (DataOut !== 8'h11) begin bad++; $display("FAIL ovf_head got=%h exp=11", DataOut); end
    total++; if (StatusOut !== 8'h64) begin bad++; $display("FAIL ovf_full got=%h exp=64", StatusOut); end
    push(8'h66); #1;
    total++; if (StatusOut !== 8'hE4) begin bad++; $display("FAIL ovf_set got=%h exp=e4", StatusOut); end
    we = 1'b1; Address = 8'hFE; RegData = 8'hFF;
    step();
    we = 1'b0; #1;
    total++; if (StatusOut !== 8'h64) begin bad++; $display("FAIL ovf_clear got=%h exp=64", StatusOut); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_b [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || DataOut !== exp_b[i]) begin
        bad++; $display("FAIL drain_byte%0d got=%b/%h exp=1/%h", i, out_valid, DataOut, exp_b[i]);
      end
      out_ack = 1'b1; step();
      if (i == 0) begin
        step();
        total++; if (out_valid !== 1'b0 || StatusOut[6] !== 1'b1) begin
          bad++; $display("FAIL drain_ackhold got=%b/%b exp=0/1", out_valid, StatusOut[6]);
        end
      end
      out_ack = 1'b0; step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_gap%0d got=%b exp=0", i, out_valid); end
      if (i < 4) step();
    end
    total++; if (StatusOut !== 8'h10 || DataOut !== 8'h55) begin
      bad++; $display("FAIL drain_end got=%h/%h exp=10/55", StatusOut, DataOut);
    end
  endtask

  task automatic test_passthrough();
    we = 1'b1; Address = 8'h10; RegData = 8'h77; #1;
    total++; if (wren !== 1'b1 || io_sel !== 1'b0 || StatusOut !== 8'h00) begin
      bad++; $display("FAIL pass_mem got=%b/%b/%h exp=1/0/00", wren, io_sel, StatusOut);
    end
    step();
    we = 1'b0; Address = 8'hFE; step();
    total++; if (StatusOut !== 8'h10 || out_valid !== 1'b0) begin
      bad++; $display("FAIL pass_fifo got=%h/%b exp=10/0", StatusOut, out_valid);
    end
    we = 1'b1; Address = 8'hFF; #1;
    total++; if (wren !== 1'b0 || io_sel !== 1'b1) begin
      bad++; $display("FAIL pass_io got=%b/%b exp=0/1", wren, io_sel);
    end
    we = 1'b0; Address = 8'hFE;
  endtask

  task automatic test_midreset();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); #1;
    total++; if (StatusOut !== 8'h43 || DataOut !== 8'hA1) begin
      bad++; $display("FAIL mrst_pre got=%h/%h exp=43/a1", StatusOut, DataOut);
    end
    rst = 1'b1; we = 1'b1; Address = 8'hFF; RegData = 8'h99;
    step();
    rst = 1'b0; we = 1'b0; Address = 8'hFE; #1;
    total++; if (out_valid !== 1'b0 || DataOut !== 8'h00 || StatusOut !== 8'h10) begin
      bad++; $display("FAIL mrst_post got=%b/%h/%h exp=0/00/10", out_valid, DataOut, StatusOut);
    end
    out_ack = 1'b1; step(); out_ack = 1'b0; step(); step(); step();
    total++; if (out_valid !== 1'b0 || DataOut !== 8'h00 || StatusOut !== 8'h10) begin
      bad++; $display("FAIL mrst_ack got=%b/%h/%h exp=0/00/10", out_valid, DataOut, StatusOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b = '{8'hB2, 8'hB3, 8'hB4, 8'hB5};
    out_ack = 1'b0;
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    out_ack = 1'b1; step(); out_ack = 1'b0; step(); #1;
    total++; if (StatusOut !== 8'h24) begin bad++; $display("FAIL b2b_idlefull got=%h exp=24", StatusOut); end
    push(8'hB5); #1;
    total++; if (StatusOut !== 8'h64 || DataOut !== 8'hB1) begin
      bad++; $display("FAIL b2b_accept got=%h/%h exp=64/b1", StatusOut, DataOut);
    end
    for (int i = 0; i < 4; i++) begin
      out_ack = 1'b1; step(); out_ack = 1'b0; step(); step();
      total++; if (out_valid !== 1'b1 || DataOut !== exp_b[i]) begin
        bad++; $display("FAIL b2b_byte%0d got=%b/%h exp=1/%h", i, out_valid, DataOut, exp_b[i]);
      end
    end
    out_ack = 1'b1; step(); out_ack = 1'b0; step(); step();
    total++; if (StatusOut !== 8'h10 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%h/%b exp=10/0", StatusOut, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_drain();
    test_passthrough();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
